vec_fwd_mux_stage: RTL and testbench

//  Registered vector forwarding-select stage for the hazard unit.
//  - Picks one of NSRC vector sources per instruction: regfile, EX/MEM, MEM/WB, WB bypass.
//  - Applies a per-lane enable mask to the chosen vector.
//  - Captures the result into a valid/ready pipeline register with a 1-entry skid buffer.
//  - Sits between operand fetch and the vector EX stage; full throughput, 1-cycle latency.

---
 rtl/vec_fwd_mux_stage.sv | 98 +++++++++
 tb/tb_vec_fwd_mux_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_fwd_mux_stage.sv
// Vector forwarding-select stage: source mux, lane mask, valid/ready register with 1-entry skid.
// Optional forwarded-transfer counter built only when VEC_FWD_PERF_EN is defined.
module vec_fwd_mux_stage #(
  parameter int  WIDTH = 8,
  parameter int  LANES = 10,
  parameter int  NSRC  = 4,
  localparam int SELW  = $clog2(NSRC)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [SELW-1:0]                        sel,
  input  logic [NSRC-1:0][LANES-1:0][WIDTH-1:0]  d,
  input  logic [LANES-1:0]                       lane_en,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LANES-1:0][WIDTH-1:0]            q,
  output logic [SELW-1:0]                        q_sel,
  output logic [15:0]                            fwd_count
);

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  logic [SELW-1:0] sel_idx;
  vec_t            v;
  vec_t            skid_q;
  logic [SELW-1:0] skid_sel;
  logic            skid_valid;
  logic            acc;
  logic            drain;

  // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
  always_comb begin
    sel_idx = '0;
    if (int'(sel) < NSRC) sel_idx = sel;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) v[i] = d[sel_idx][i];
    end
  end

  // in_ready depends only on registered state, so out_ready never reaches it combinationally.
  assign in_ready = ~skid_valid;
  assign acc      = in_valid & in_ready;
  assign drain    = ~out_valid | out_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      q          <= '0;
      q_sel      <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        q          <= skid_q;
        q_sel      <= skid_sel;
        skid_valid <= 1'b0;
      end else if (acc) begin
        q     <= v;
        q_sel <= sel;
      end
      out_valid <= skid_valid | acc;
    end else if (acc) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: skid payload is qualified by skid_valid, so it needs no reset and stays a plain data register.
  always_ff @(posedge clk) begin
    if (!flush && !drain && acc) begin
      skid_q   <= v;
      skid_sel <= sel;
    end
  end

`ifdef VEC_FWD_PERF_EN
  logic [15:0] fwd_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_cnt <= '0;
    end else if (!flush && acc && (sel != '0) && (fwd_cnt != 16'hFFFF)) begin
      fwd_cnt <= fwd_cnt + 16'd1;
    end
  end

  assign fwd_count = fwd_cnt;
`else
  assign fwd_count = 16'h0;
`endif

endmodule

// File: tb/tb_vec_fwd_mux_stage.sv
// Directed bench for vec_fwd_mux_stage; a second instance with NSRC=5 covers out-of-range selects.
module tb_vec_fwd_mux_stage;

  localparam int WIDTH = 8;
  localparam int LANES = 10;
  localparam int NSRC  = 4;
  localparam int SELW  = 2;
  localparam int NSRC5 = 5;
`ifdef VEC_FWD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  logic                                   clk = 1'b0;
  logic                                   reset;
  logic                                   flush;
  logic                                   in_valid;
  logic                                   in_ready;
  logic [SELW-1:0]                        sel;
  logic [NSRC-1:0][LANES-1:0][WIDTH-1:0]  d;
  logic [LANES-1:0]                       lane_en;
  logic                                   out_valid;
  logic                                   out_ready;
  vec_t                                   q;
  logic [SELW-1:0]                        q_sel;
  logic [15:0]                            fwd_count;

  logic [2:0]                             sel3;
  logic [NSRC5-1:0][LANES-1:0][WIDTH-1:0] d5;
  logic                                   in_ready5;
  logic                                   out_valid5;
  vec_t                                   q5;
  logic [2:0]                             q_sel5;
  logic [15:0]                            fwd_count5;

  int n_checks = 0;
  int n_errs   = 0;

  vec_fwd_mux_stage #(.WIDTH(WIDTH), .LANES(LANES), .NSRC(NSRC)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .d(d), .lane_en(lane_en), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .q_sel(q_sel), .fwd_count(fwd_count)
  );

  vec_fwd_mux_stage #(.WIDTH(WIDTH), .LANES(LANES), .NSRC(NSRC5)) u_oor (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready5),
    .sel(sel3), .d(d5), .lane_en(lane_en), .out_valid(out_valid5), .out_ready(out_ready),
    .q(q5), .q_sel(q_sel5), .fwd_count(fwd_count5)
  );

  always #5 clk = ~clk;

  function automatic vec_t pattern(input logic [7:0] base);
    vec_t r;
    for (int i = 0; i < LANES; i++) r[i] = base + 8'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t va, vb, vc, vx, vm, vz;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    sel = 2'd1; sel3 = 3'd0; lane_en = '1;
    for (int s = 0; s < NSRC; s++)  d[s]  = pattern(8'(s * 64));
    for (int s = 0; s < NSRC5; s++) d5[s] = pattern(8'(s * 32 + 16));

    // Reset with in_valid high: nothing may be captured.
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_q", q, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fwd_count", fwd_count, 0);
    tick(); tick();
    check("rst_hold_out_valid", out_valid, 0);
    check("rst_hold_q", q, 0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Streaming with sel=1: q follows d[1] with one cycle of latency.
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int s = 0; s < NSRC; s++) d[s] = pattern(8'(s * 64 + k));
      vz = pattern(8'(64 + k));
      tick();
      check("stream_out_valid", out_valid, 1);
      check("stream_q", q, vz);
      check("stream_q_sel", q_sel, 1);
      check("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_idle_out_valid", out_valid, 0);
    check("stream_fwd_count", fwd_count, PERF ? 10 : 0);

    // Backpressure: A held in q, B parks in skid, C waits until the skid drains.
    va = pattern(8'hA0); vb = pattern(8'hB0); vc = pattern(8'hC0);
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 2'd2; d[2] = va;
    tick();
    check("bp_a_q", q, va);
    check("bp_a_in_ready", in_ready, 1);
    sel = 2'd3; d[3] = vb;
    tick();
    check("bp_b_q_holds_a", q, va);
    check("bp_b_q_sel", q_sel, 2);
    check("bp_b_in_ready", in_ready, 0);
    sel = 2'd1; d[1] = vc;
    tick();
    check("bp_c_blocked_q", q, va);
    check("bp_c_blocked_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("bp_drain_q_b", q, vb);
    check("bp_drain_q_sel_b", q_sel, 3);
    check("bp_drain_out_valid", out_valid, 1);
    check("bp_drain_in_ready", in_ready, 1);
    tick();
    check("bp_q_c", q, vc);
    check("bp_q_sel_c", q_sel, 1);
    in_valid = 1'b0;
    tick();
    check("bp_idle_out_valid", out_valid, 0);
    check("bp_fwd_count", fwd_count, PERF ? 13 : 0);

    // Lane mask plus out-of-range select on the NSRC=5 instance.
    in_valid = 1'b1; lane_en = 10'b0000000101;
    sel = 2'd2; d[2] = pattern(8'h40); sel3 = 3'd5;
    vm = '0; vm[0] = 8'h40; vm[2] = 8'h42;
    vz = '0; vz[0] = 8'h10; vz[2] = 8'h12;
    tick();
    check("mask_q", q, vm);
    check("oor5_mask_q", q5, vz);
    check("oor5_q_sel", q_sel5, 5);
    lane_en = '1; sel = 2'd0; sel3 = 3'd7;
    for (int s = 0; s < NSRC; s++) d[s] = pattern(8'(s * 64 + 32));
    tick();
    check("sel0_q", q, pattern(8'h20));
    check("oor7_q", q5, pattern(8'h10));
    sel3 = 3'd4;
    tick();
    check("inrange4_q", q5, pattern(8'h90));
    in_valid = 1'b0; sel3 = 3'd0;
    tick();
    check("mask_fwd_count", fwd_count, PERF ? 14 : 0);

    // Flush with skid full: both entries die and q keeps its stale value.
    vx = pattern(8'h60); vz = pattern(8'h70);
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1; d[1] = vx;
    tick();
    d[1] = vz;
    tick();
    check("fl_skid_full_in_ready", in_ready, 0);
    flush = 1'b1; d[1] = pattern(8'hE0);
    tick();
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_q_stale", q, vx);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("fl_no_skid_replay", out_valid, 0);
    // Flush while input is acceptable: the offer is dropped and not counted.
    flush = 1'b1; in_valid = 1'b1; d[1] = pattern(8'hF0);
    tick();
    check("fl2_out_valid", out_valid, 0);
    check("fl2_q_stale", q, vx);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("fl2_dropped", out_valid, 0);
    check("fl_fwd_count", fwd_count, PERF ? 16 : 0);

`ifdef VEC_FWD_PERF_EN
    // Drive the counter into saturation.
    in_valid = 1'b1; sel = 2'd1;
    repeat (65535 - 16 + 4) @(posedge clk);
    #1;
    check("perf_saturate", fwd_count, 16'hFFFF);
    tick();
    check("perf_saturate_hold", fwd_count, 16'hFFFF);
    in_valid = 1'b0;
    tick();
`endif

    // Asynchronous reset mid-transfer, applied between clock edges.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3; d[3] = pattern(8'h33);
    tick(); tick();
    check("pre_async_in_ready", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_in_ready", in_ready, 1);
    check("async_q", q, 0);
    check("async_q_sel", q_sel, 0);
    check("async_fwd_count", fwd_count, 0);
    tick();
    reset = 1'b0; in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
